// File: rtl/local_bus_arbiter_pkg.sv
// Shared definitions for the 68040 local bus arbiter.
//   - arb_state_t : arbiter FSM states
//   - OWNER_*     : fixed codes driven on the OWNER port
//   - DEF_*       : default parameter values
//   - idx_width / cnt_width : width helpers for indices and counters
package local_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        CPU_OWN,
        CPU_RELEASE,
        TURN,
        ALT_GRANT,
        ALT_OWN,
        ALT_RELEASE
    } arb_state_t;

    localparam logic [2:0] OWNER_CPU  = 3'd0;
    localparam logic [2:0] OWNER_NONE = 3'd7;

    localparam int DEF_NUM_MASTERS   = 2;
    localparam int DEF_MAX_TENURE    = 64;
    localparam int DEF_GRANT_TIMEOUT = 16;
    localparam int DEF_TURNAROUND    = 1;

    // Index width for n items; never zero so a single master still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/local_bus_arbiter_rr_select.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per alternate master
//   ptr    : highest-priority index for this pick
//   winner : first requesting index at or after ptr, wrapping to 0
//   valid  : at least one request is present
module local_bus_arbiter_rr_select
    import local_bus_arbiter_pkg::*;
#(
    parameter int N     = DEF_NUM_MASTERS,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic             hi_hit;
    logic             lo_hit;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the last hit written is the lowest index. The
    // "hi" search covers indices at or above ptr; the "lo" search covers
    // everything and provides the wrap-around choice.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned in always_comb would infer a latch.
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (IDX_W'(j) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(j);
                end
                lo_hit = 1'b1;
                lo_idx = IDX_W'(j);
            end
        end
        valid  = lo_hit;
        winner = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/local_bus_arbiter.sv
// 68040 local bus arbiter: the CPU is the parked default owner; alternate
// masters are served round-robin with a bounded tenure, sequenced with the
// BR/BG/BB handshake so an owner's cycle is never split.
//   CLK40    : bus clock, rising edge
//   nRESET   : asynchronous active-low reset
//   nBR_CPU  : CPU bus request (active low)
//   nBG_CPU  : CPU bus grant (active low, registered)
//   nBB      : wired bus-busy (active low, asynchronous, synchronized here)
//   REQ      : alternate master requests (active high)
//   GNT      : alternate master grants (one-hot or zero, registered)
//   OWNER    : 0 = CPU, 1..NUM_MASTERS = master index + 1, 7 = in transition
//   ARB_BUSY : high whenever the CPU is not the parked owner
module local_bus_arbiter
    import local_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
    parameter int MAX_TENURE    = DEF_MAX_TENURE,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int TURNAROUND    = DEF_TURNAROUND
) (
    input  logic                   CLK40,
    input  logic                   nRESET,
    input  logic                   nBR_CPU,
    output logic                   nBG_CPU,
    input  logic                   nBB,
    input  logic [NUM_MASTERS-1:0] REQ,
    output logic [NUM_MASTERS-1:0] GNT,
    output logic [2:0]             OWNER,
    output logic                   ARB_BUSY
);

    localparam int IDX_W     = idx_width(NUM_MASTERS);
    // TURN and ALT_GRANT always last at least one cycle.
    localparam int TURN_LAST = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
    localparam int GTO_LAST  = (GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0;
    localparam int TEN_W     = cnt_width(MAX_TENURE);
    localparam int GTO_W     = cnt_width(GTO_LAST);
    localparam int TRN_W     = cnt_width(TURN_LAST);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] winner, winner_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [TEN_W-1:0] tenure_cnt, tenure_n;
    logic [GTO_W-1:0] grant_cnt, grant_n;
    logic [TRN_W-1:0] turn_cnt, turn_n;
    logic             rel_seen, rel_seen_n;   // bus seen idle on the previous edge
    logic             from_alt, from_alt_n;   // TURN was entered from the alternate side
    logic [1:0]       bb_sync;
    logic             bus_idle;

    logic [NUM_MASTERS-1:0] gnt_n;
    logic [2:0]             owner_n;
    logic                   nbg_n;

    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic [NUM_MASTERS-1:0] win_mask;
    logic                   other_req;
    logic [IDX_W-1:0]       after_winner;

    local_bus_arbiter_rr_select #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req    (REQ),
        .ptr    (ptr),
        .winner (sel_idx),
        .valid  (sel_valid)
    );

    // nBB is pulled up off-chip, so the synchronizer resets to "idle".
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            bb_sync <= 2'b11;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, independent of statement order.
            bb_sync <= {bb_sync[0], nBB};
        end
    end

    assign bus_idle     = bb_sync[1];
    assign win_mask     = NUM_MASTERS'(1) << winner;
    assign other_req    = |(REQ & ~win_mask);
    assign after_winner = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        state_n    = state;
        winner_n   = winner;
        ptr_n      = ptr;
        tenure_n   = tenure_cnt;
        grant_n    = grant_cnt;
        turn_n     = turn_cnt;
        rel_seen_n = rel_seen;
        from_alt_n = from_alt;

        case (state)
            CPU_OWN: begin
                if (sel_valid) begin
                    winner_n   = sel_idx;
                    rel_seen_n = 1'b0;
                    state_n    = CPU_RELEASE;
                end
            end

            CPU_RELEASE: begin
                if (!REQ[winner] && !sel_valid) begin
                    state_n = CPU_OWN;
                end else begin
                    if (!REQ[winner]) winner_n = sel_idx;
                    // Two consecutive idle samples cover a locked CPU cycle.
                    if (bus_idle) begin
                        if (rel_seen) begin
                            state_n    = TURN;
                            turn_n     = '0;
                            from_alt_n = 1'b0;
                        end else begin
                            rel_seen_n = 1'b1;
                        end
                    end else begin
                        rel_seen_n = 1'b0;
                    end
                end
            end

            TURN: begin
                if (turn_cnt >= TRN_W'(TURN_LAST)) begin
                    state_n = CPU_OWN;
                    grant_n = '0;
                    if (from_alt) begin
                        // After a tenure only the master at the pointer may
                        // follow, and only if the CPU is not asking.
                        if (REQ[ptr] && nBR_CPU) begin
                            winner_n = ptr;
                            state_n  = ALT_GRANT;
                        end
                    end else if (REQ[winner]) begin
                        state_n = ALT_GRANT;
                    end else if (sel_valid) begin
                        winner_n = sel_idx;
                        state_n  = ALT_GRANT;
                    end
                end else begin
                    turn_n = turn_cnt + 1'b1;
                end
            end

            ALT_GRANT: begin
                if (!bus_idle) begin
                    state_n  = ALT_OWN;
                    tenure_n = TEN_W'(1);
                end else if (!REQ[winner] || grant_cnt == GTO_W'(GTO_LAST)) begin
                    state_n    = TURN;
                    turn_n     = '0;
                    from_alt_n = 1'b1;
                    ptr_n      = after_winner;
                end else begin
                    grant_n = grant_cnt + 1'b1;
                end
            end

            ALT_OWN: begin
                if (tenure_cnt != TEN_W'(MAX_TENURE)) tenure_n = tenure_cnt + 1'b1;
                if (!REQ[winner] ||
                    (tenure_cnt == TEN_W'(MAX_TENURE) && (!nBR_CPU || other_req))) begin
                    state_n = ALT_RELEASE;
                end
            end

            ALT_RELEASE: begin
                if (bus_idle) begin
                    state_n    = TURN;
                    turn_n     = '0;
                    from_alt_n = 1'b1;
                    ptr_n      = after_winner;
                end
            end

            default: state_n = CPU_OWN;
        endcase

        // Outputs are decoded from the next state and registered below.
        nbg_n   = (state_n != CPU_OWN);
        gnt_n   = '0;
        owner_n = OWNER_NONE;
        if (state_n == CPU_OWN) begin
            owner_n = OWNER_CPU;
        end else if (state_n == ALT_GRANT || state_n == ALT_OWN) begin
            gnt_n   = NUM_MASTERS'(1) << winner_n;
            owner_n = 3'(winner_n) + 3'd1;
        end
    end

    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state      <= CPU_OWN;
            winner     <= '0;
            ptr        <= '0;
            tenure_cnt <= '0;
            grant_cnt  <= '0;
            turn_cnt   <= '0;
            rel_seen   <= 1'b0;
            from_alt   <= 1'b0;
            nBG_CPU    <= 1'b0;
            GNT        <= '0;
            OWNER      <= OWNER_CPU;
            ARB_BUSY   <= 1'b0;
        end else begin
            state      <= state_n;
            winner     <= winner_n;
            ptr        <= ptr_n;
            tenure_cnt <= tenure_n;
            grant_cnt  <= grant_n;
            turn_cnt   <= turn_n;
            rel_seen   <= rel_seen_n;
            from_alt   <= from_alt_n;
            nBG_CPU    <= nbg_n;
            GNT        <= gnt_n;
            OWNER      <= owner_n;
            ARB_BUSY   <= nbg_n;
        end
    end

endmodule
